// File: rtl/trap_ctrl_pkg.sv
// Shared trap-controller definitions: sequencer states, CSR addresses, cause codes.
// Cause codes are RV32 mcause values; bit 31 flags an interrupt.
package trap_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_SAVE_EPC,
      ST_SAVE_CAUSE,
      ST_SAVE_STATUS,
      ST_JUMP,
      ST_HANDLER,
      ST_RESTORE,
      ST_RETURN
   } state_t;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] CAUSE_SM_DEFAULT = 32'h0000_0018;
   localparam logic [31:0] CAUSE_ECALL      = 32'h0000_000B;
   localparam logic [31:0] CAUSE_UART_IRQ   = 32'h8000_000B;

   localparam int MIE_MEIE     = 11;
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational trap request selection: stack_mismatch > ecall > enabled uart interrupt.
// Zero latency; no flow control.
module trap_prio_enc
   import trap_ctrl_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] SM_CAUSE = CAUSE_SM_DEFAULT
) (
   input  logic            ecall,
   input  logic            stack_mismatch,
   input  logic            irq,
   output logic            take,
   output logic [XLEN-1:0] cause
);

   always_comb begin
      take  = stack_mismatch | ecall | irq;
      cause = '0;
      if (stack_mismatch)
         cause = XLEN'(SM_CAUSE);
      else if (ecall)
         cause = XLEN'(CAUSE_ECALL);
      else if (irq)
         cause = XLEN'(CAUSE_UART_IRQ);
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: flush, save mepc/mcause/mstatus, jump; restore and return on mret.
// Redirect 5 cycles after the request; pipeline held via stall. Define TRAP_VECTORED_EN for vectored interrupts.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] SM_CAUSE = 32'h18
) (
   input  logic            clk,
   input  logic            Rst,
   input  logic            ecall,
   input  logic            stack_mismatch,
   input  logic            uart_IRQ,
   input  logic            mret,
   input  logic [XLEN-1:0] mstatus,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic [XLEN-1:0] ID_EX_pres_addr,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata,
   output logic            flush,
   output logic            stall,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_addr,
   output logic            trap_active,
   output logic            trap_error
);

   state_t          state;
   logic [XLEN-1:0] epc, cause, target;
   logic            take;
   logic [XLEN-1:0] entry_cause, entry_target, base;
   logic [XLEN-1:0] save_status, restore_status;
   logic            irq_en;

   assign irq_en = uart_IRQ & mie[MIE_MEIE] & mstatus[MSTATUS_MIE];
   assign base   = {mtvec[XLEN-1:2], 2'b00};

   trap_prio_enc #(.XLEN(XLEN), .SM_CAUSE(SM_CAUSE)) u_prio (
      .ecall          (ecall),
      .stack_mismatch (stack_mismatch),
      .irq            (irq_en),
      .take           (take),
      .cause          (entry_cause)
   );

`ifdef TRAP_VECTORED_EN
   // Only interrupts vector; exceptions always land on the base address.
   assign entry_target = (entry_cause[31] && mtvec[1:0] == 2'b01)
                       ? base + XLEN'({entry_cause[30:0], 2'b00}) : base;
`else
   assign entry_target = base;
`endif

   always_comb begin
      save_status = mstatus;
      save_status[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      save_status[MSTATUS_MIE]  = 1'b0;
      restore_status = mstatus;
      restore_status[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      restore_status[MSTATUS_MPIE] = 1'b1;
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, mie[XLEN-1:MIE_MEIE+1], mie[MIE_MEIE-1:0], mtvec[1:0]};

   always_ff @(posedge clk) begin
      if (!Rst) begin
         state         <= ST_IDLE;
         epc           <= '0;
         cause         <= '0;
         target        <= '0;
         csr_we        <= 1'b0;
         csr_addr      <= '0;
         csr_wdata     <= '0;
         flush         <= 1'b0;
         stall         <= 1'b0;
         redirect      <= 1'b0;
         redirect_addr <= '0;
         trap_active   <= 1'b0;
         trap_error    <= 1'b0;
      end else begin
         csr_we        <= 1'b0;
         csr_addr      <= '0;
         csr_wdata     <= '0;
         flush         <= 1'b0;
         stall         <= 1'b0;
         redirect      <= 1'b0;
         redirect_addr <= '0;
         trap_active   <= 1'b0;
         // Outputs are registered: each arm drives the outputs of the state it enters.
         case (state)
            ST_IDLE: if (take) begin
               state  <= ST_FLUSH;
               epc    <= ID_EX_pres_addr;
               cause  <= entry_cause;
               target <= entry_target;
               flush  <= 1'b1;
               stall  <= 1'b1;
            end
            ST_FLUSH: begin
               state     <= ST_SAVE_EPC;
               csr_we    <= 1'b1;
               csr_addr  <= CSR_MEPC;
               csr_wdata <= epc;
               stall     <= 1'b1;
            end
            ST_SAVE_EPC: begin
               state     <= ST_SAVE_CAUSE;
               csr_we    <= 1'b1;
               csr_addr  <= CSR_MCAUSE;
               csr_wdata <= cause;
               stall     <= 1'b1;
            end
            ST_SAVE_CAUSE: begin
               state     <= ST_SAVE_STATUS;
               csr_we    <= 1'b1;
               csr_addr  <= CSR_MSTATUS;
               csr_wdata <= save_status;
               stall     <= 1'b1;
            end
            ST_SAVE_STATUS: begin
               state         <= ST_JUMP;
               redirect      <= 1'b1;
               redirect_addr <= target;
               stall         <= 1'b1;
            end
            ST_JUMP: begin
               state       <= ST_HANDLER;
               trap_active <= 1'b1;
            end
            ST_HANDLER: begin
               if (ecall | stack_mismatch)
                  trap_error <= 1'b1;
               if (mret) begin
                  state     <= ST_RESTORE;
                  csr_we    <= 1'b1;
                  csr_addr  <= CSR_MSTATUS;
                  csr_wdata <= restore_status;
                  stall     <= 1'b1;
               end else begin
                  trap_active <= 1'b1;
               end
            end
            ST_RESTORE: begin
               state         <= ST_RETURN;
               redirect      <= 1'b1;
               redirect_addr <= mepc;
               stall         <= 1'b1;
            end
            ST_RETURN: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table of trap entry/return scenarios plus hand-written corner sequences.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        Rst = 1'b0;
   logic        ecall = 1'b0, stack_mismatch = 1'b0, uart_IRQ = 1'b0, mret = 1'b0;
   logic [31:0] mstatus = '0, mie = '0, mtvec = '0, mepc = '0, ID_EX_pres_addr = '0;
   logic        csr_we, flush, stall, redirect, trap_active, trap_error;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, redirect_addr;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(32), .SM_CAUSE(32'h18)) dut (
      .clk             (clk),
      .Rst             (Rst),
      .ecall           (ecall),
      .stack_mismatch  (stack_mismatch),
      .uart_IRQ        (uart_IRQ),
      .mret            (mret),
      .mstatus         (mstatus),
      .mie             (mie),
      .mtvec           (mtvec),
      .mepc            (mepc),
      .ID_EX_pres_addr (ID_EX_pres_addr),
      .csr_we          (csr_we),
      .csr_addr        (csr_addr),
      .csr_wdata       (csr_wdata),
      .flush           (flush),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_addr   (redirect_addr),
      .trap_active     (trap_active),
      .trap_error      (trap_error)
   );

   typedef struct {
      logic        ecall, sm, irq, mret;
      logic [31:0] mie, mstatus, mtvec, pc, mepc;
      logic [31:0] cause, target, save_st, rest_st;
   } vec_t;

   vec_t vt[5];
   int   checks = 0;
   int   errors = 0;

   // {csr_we, csr_addr, csr_wdata, flush, stall, redirect, redirect_addr, trap_active}
   logic [80:0] obs;
   assign obs = {csr_we, csr_addr, csr_wdata, flush, stall, redirect, redirect_addr, trap_active};

   function automatic logic [80:0] pk(input logic we, input logic [11:0] a, input logic [31:0] d,
                                      input logic fl, input logic st, input logic rd,
                                      input logic [31:0] ra, input logic act);
      return {we, a, d, fl, st, rd, ra, act};
   endfunction

   task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Requests land in IDLE cycle N; checks cycles N+1..N+6.
   task automatic enter(input vec_t v, input string tag);
      ecall = v.ecall; stack_mismatch = v.sm; uart_IRQ = v.irq; mret = v.mret;
      mie = v.mie; mstatus = v.mstatus; mtvec = v.mtvec; ID_EX_pres_addr = v.pc;
      step();
      chk({tag, " flush"}, obs, pk(1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0));
      ecall = 1'b0; stack_mismatch = 1'b0; uart_IRQ = 1'b0; mret = 1'b0;
      ID_EX_pres_addr = 32'hDEAD_0000; mtvec = 32'hFFFF_FF01;
      step();
      chk({tag, " save_epc"}, obs, pk(1'b1, 12'h341, v.pc, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
      step();
      chk({tag, " save_cause"}, obs, pk(1'b1, 12'h342, v.cause, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
      step();
      chk({tag, " save_status"}, obs, pk(1'b1, 12'h300, v.save_st, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
      mstatus = v.save_st;
      step();
      chk({tag, " jump"}, obs, pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b1, v.target, 1'b0));
      step();
      chk({tag, " handler"}, obs, pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
   endtask

   task automatic leave(input vec_t v, input string tag);
      mepc = v.mepc;
      mret = 1'b1;
      step();
      chk({tag, " restore"}, obs, pk(1'b1, 12'h300, v.rest_st, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
      mret = 1'b0;
      step();
      chk({tag, " return"}, obs, pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 1'b1, v.mepc, 1'b0));
      step();
      chk({tag, " idle"}, obs, '0);
   endtask

   initial begin
      // ecall, plain base
      vt[0] = '{ecall:1, sm:0, irq:0, mret:0, mie:32'h0, mstatus:32'h8, mtvec:32'h400,
                pc:32'h100, mepc:32'h104, cause:32'hB, target:32'h400,
                save_st:32'h80, rest_st:32'h88};
      // stack_mismatch beats ecall
      vt[1] = '{ecall:1, sm:1, irq:0, mret:0, mie:32'h0, mstatus:32'h0, mtvec:32'h800,
                pc:32'h200, mepc:32'h204, cause:32'h18, target:32'h800,
                save_st:32'h0, rest_st:32'h80};
      // enabled uart interrupt, vectored-mode mtvec
      vt[2] = '{ecall:0, sm:0, irq:1, mret:0, mie:32'h800, mstatus:32'h1808, mtvec:32'h401,
                pc:32'h300, mepc:32'h300, cause:32'h8000_000B, target:32'h400,
                save_st:32'h1880, rest_st:32'h1888};
`ifdef TRAP_VECTORED_EN
      vt[2].target = 32'h42C;
`endif
      // ecall with simultaneous mret: trap wins; exception ignores vectoring
      vt[3] = '{ecall:1, sm:0, irq:0, mret:1, mie:32'h800, mstatus:32'h8, mtvec:32'h401,
                pc:32'h1000, mepc:32'h1004, cause:32'hB, target:32'h400,
                save_st:32'h80, rest_st:32'h88};
      // stack_mismatch alone, all-ones mstatus, reserved mode bits masked
      vt[4] = '{ecall:0, sm:1, irq:0, mret:0, mie:32'h0, mstatus:32'hFFFF_FFFF, mtvec:32'h1003,
                pc:32'h2000, mepc:32'h2004, cause:32'h18, target:32'h1000,
                save_st:32'hFFFF_FFF7, rest_st:32'hFFFF_FFFF};

      step();
      step();
      chk("reset outputs", obs, '0);
      chk("reset trap_error", {80'b0, trap_error}, 81'd0);
      Rst = 1'b1;
      step();

      // interrupt gated by mstatus.MIE, then by mie.MEIE
      uart_IRQ = 1'b1; mie = 32'h800; mstatus = 32'h0;
      step();
      step();
      chk("irq gated by mstatus", obs, '0);
      mie = 32'h0; mstatus = 32'h8;
      step();
      step();
      chk("irq gated by mie", obs, '0);
      uart_IRQ = 1'b0;

      mret = 1'b1;
      step();
      step();
      chk("mret in idle", obs, '0);
      mret = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         enter(vt[i], $sformatf("vec%0d", i));
         leave(vt[i], $sformatf("vec%0d", i));
      end
      chk("no error after clean traps", {80'b0, trap_error}, 81'd0);

      // nested ecall while in handler: flagged, not taken
      enter(vt[0], "nest");
      ecall = 1'b1;
      step();
      chk("nest hold1", obs, pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
      chk("nest trap_error", {80'b0, trap_error}, 81'd1);
      step();
      chk("nest hold2", obs, pk(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
      ecall = 1'b0;
      leave(vt[0], "nest");
      chk("trap_error sticky", {80'b0, trap_error}, 81'd1);

      // reset while writing mcause abandons the sequence
      mstatus = 32'h8; mtvec = 32'h400; ID_EX_pres_addr = 32'h500;
      ecall = 1'b1;
      step();
      ecall = 1'b0;
      step();
      step();
      chk("pre-reset save_cause", obs, pk(1'b1, 12'h342, 32'hB, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0));
      Rst = 1'b0;
      step();
      chk("mid reset outputs", obs, '0);
      chk("mid reset trap_error", {80'b0, trap_error}, 81'd0);
      Rst = 1'b1;
      step();
      chk("post reset idle1", obs, '0);
      step();
      step();
      chk("post reset idle3", obs, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath/CSR width.
REQ-002 SHALL have parameter SM_CAUSE, 32'h18, mcause code for stack_mismatch.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port Rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports ecall, stack_mismatch  in  1 each  exception requests, sampled in IDLE.
REQ-006 SHALL have port uart_IRQ  in  1  level interrupt request.
REQ-007 SHALL have port mret  in  1  trap-return instruction in EX.
REQ-008 SHALL have ports mstatus, mie, mtvec, mepc  in  XLEN each  current CSR values.
REQ-009 SHALL have port ID_EX_pres_addr  in  XLEN  PC of the instruction in EX.
REQ-010 SHALL have ports csr_we  out 1, csr_addr  out 12, csr_wdata  out XLEN  CSR write port.
REQ-011 SHALL have ports flush, stall, redirect  out 1 each; redirect_addr  out XLEN.
REQ-012 SHALL have ports trap_active  out 1  (handler running), trap_error  out 1  (sticky).

Function
REQ-013 SHALL implement FSM IDLE, FLUSH, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, JUMP, HANDLER, RESTORE, RETURN.
REQ-014 IDLE: take trap when stack_mismatch | ecall | (uart_IRQ & mie[11] & mstatus[3]); else stay.
REQ-015 Priority SHALL be stack_mismatch > ecall > uart_IRQ; cause latched on entry: SM_CAUSE, 32'h0000_000B, 32'h8000_000B.
REQ-016 On entry SHALL latch ID_EX_pres_addr as epc and mtvec as target base.
REQ-017 FLUSH (1 cycle): flush=1, stall=1.
REQ-018 SAVE_EPC/SAVE_CAUSE/SAVE_STATUS: one cycle each, csr_we=1 to 12'h341=epc, 12'h342=cause, 12'h300=mstatus with bit7=old bit3, bit3=0; stall=1.
REQ-019 JUMP (1 cycle): redirect=1, redirect_addr=target, stall=1; next HANDLER.
REQ-020 HANDLER: trap_active=1; mret -> RESTORE; all trap requests ignored.
REQ-021 ecall or stack_mismatch in HANDLER SHALL set trap_error (no nesting); cleared only by reset.
REQ-022 RESTORE: csr_we=1, 12'h300, bit3=mstatus[7], bit7=1, stall=1.
REQ-023 RETURN: redirect=1, redirect_addr=mepc (current input), stall=1; next IDLE.
REQ-024 Trap entry latency: request in IDLE cycle N -> redirect in cycle N+5.
REQ-025 mret in IDLE SHALL be ignored; simultaneous mret and trap request in IDLE: trap wins.
REQ-026 csr_we SHALL be 0 outside SAVE_* and RESTORE; csr_addr/csr_wdata 0 when csr_we=0.
REQ-027 uart_IRQ deasserting after entry SHALL not abort the sequence.

Reset
REQ-028 Rst=0 at posedge clk SHALL force IDLE and all outputs 0, including trap_error and latched epc/cause/target.
REQ-029 Reset mid-sequence SHALL abandon it with no further CSR write or redirect.

Configuration
REQ-030 With TRAP_VECTORED_EN defined: interrupt with mtvec[1:0]==2'b01 -> target = {mtvec[XLEN-1:2],2'b00} + 4*cause[30:0]; exceptions use base.
REQ-031 Without TRAP_VECTORED_EN: target = {mtvec[XLEN-1:2],2'b00} for all causes.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, CSR address constants (300/304/305/341/342) and cause codes.
REQ-033 One sub-module trap_prio_enc SHALL do priority select and cause encoding (combinational).

Verification
REQ-034 ecall=1, ID_EX_pres_addr=32'h0000_0100, mtvec=32'h0000_0400 -> writes mepc=0x100, mcause=0xB, then redirect to 0x400 at N+5.
REQ-035 uart_IRQ=1, mie[11]=1, mstatus[3]=0 -> stays IDLE; set mstatus[3]=1 -> mcause=0x8000_000B, mstatus write clears bit3, sets bit7.
REQ-036 stack_mismatch and ecall same cycle -> mcause=0x18.
REQ-037 ecall in HANDLER -> trap_error=1, no CSR write; then mret with mepc=0x104 -> mstatus restore, redirect 0x104, IDLE.
REQ-038 Rst=0 in SAVE_CAUSE -> next cycle IDLE, csr_we=0, redirect=0, trap_error=0.
REQ-039 TRAP_VECTORED_EN, mtvec=32'h0000_0401, uart IRQ -> redirect_addr=0x42C; ecall -> 0x400.
